// File: rtl/datapath_core.sv
// datapath_core: 64-bit LEGv8-style datapath.
// A 32x64 register file (X31 reads as zero), an ALU with a latched {V,C,N,Z}
// status register, a 256-byte little-endian data RAM, a 32-bit PC and a 32-bit
// instruction register, joined by a 64-bit data bus and an address bus.
// All control comes from an external controller; there is no decode here.

module datapath_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        add_tri_sel,
    input  logic [1:0]  data_tri_sel,
    input  logic        w_reg,
    input  logic        C0,
    input  logic        mem_cs,
    input  logic        mem_write_en,
    input  logic        IR_load,
    input  logic        status_load,
    input  logic [31:0] k,
    input  logic [4:0]  FS,
    input  logic [1:0]  size,
    input  logic [4:0]  SA,
    input  logic [4:0]  SB,
    input  logic [4:0]  DA,
    input  logic [1:0]  PC_sel,
    input  logic        B_Sel,
    output logic [31:0] IR_out,
    output logic [3:0]  status,
    output logic [15:0] r0,
    output logic [15:0] r1,
    output logic [15:0] r2,
    output logic [15:0] r3,
    output logic [15:0] r4,
    output logic [15:0] r5,
    output logic [15:0] r6,
    output logic [15:0] r7
);

    // ALU operation codes carried on FS[4:2]
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    // Number of bytes moved by a RAM access of the given size code
    function automatic logic [3:0] size_to_bytes(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            2'b11:   n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

    // ---------------------------------------------------------------- state
    logic [63:0] r_regs [0:31];
    logic [7:0]  r_mem  [0:255];
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [3:0]  r_status;

    // ---------------------------------------------------------------- wires
    logic [63:0] w_port_a;
    logic [63:0] w_port_b;
    logic [63:0] w_alu_b;
    logic [63:0] w_op_a;
    logic [63:0] w_op_b;
    logic [64:0] w_sum;
    logic [63:0] w_alu_result;
    logic        w_is_add;
    logic        w_flag_v;
    logic        w_flag_c;
    logic        w_flag_n;
    logic        w_flag_z;
    logic [31:0] w_pc_plus4;
    logic [7:0]  w_addr;
    logic [3:0]  w_nbytes;
    logic [63:0] w_mem_rdata;
    logic [3:0]  w_bus_sel;
    logic [63:0] w_data_bus;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_nbytes   = size_to_bytes(size);

    // Register file read ports; X31 is hard-wired to zero
    always_comb begin
        w_port_a = 64'd0;
        w_port_b = 64'd0;
        if (SA == 5'd31) begin
            w_port_a = 64'd0;
        end else begin
            w_port_a = r_regs[SA];
        end
        if (SB == 5'd31) begin
            w_port_b = 64'd0;
        end else begin
            w_port_b = r_regs[SB];
        end
    end

    // ALU: optional operand inversion, then the selected operation
    always_comb begin
        w_alu_b      = B_Sel ? {32'd0, k} : w_port_b;
        w_op_a       = FS[0] ? ~w_port_a : w_port_a;
        w_op_b       = FS[1] ? ~w_alu_b  : w_alu_b;
        w_sum        = {1'b0, w_op_a} + {1'b0, w_op_b} + {64'd0, C0};
        w_alu_result = 64'd0;
        case (FS[4:2])
            OP_AND:   w_alu_result = w_op_a & w_op_b;
            OP_XOR:   w_alu_result = w_op_a ^ w_op_b;
            OP_ADD:   w_alu_result = w_sum[63:0];
            OP_OR:    w_alu_result = w_op_a | w_op_b;
            OP_SHL:   w_alu_result = w_op_a << w_op_b[5:0];
            OP_SHR:   w_alu_result = w_op_a >> w_op_b[5:0];
            OP_PASSB: w_alu_result = w_op_b;
            OP_PASSA: w_alu_result = w_op_a;
            default:  w_alu_result = 64'd0;
        endcase
    end

    // Flags: carry and overflow are only meaningful for the adder
    always_comb begin
        w_is_add = (FS[4:2] == OP_ADD);
        w_flag_z = (w_alu_result == 64'd0);
        w_flag_n = w_alu_result[63];
        if (w_is_add) begin
            w_flag_c = w_sum[64];
            w_flag_v = (w_op_a[63] == w_op_b[63]) && (w_sum[63] != w_op_a[63]);
        end else begin
            w_flag_c = 1'b0;
            w_flag_v = 1'b0;
        end
    end

    // Address bus source; only the low byte reaches the 256-byte RAM
    always_comb begin
        if (add_tri_sel) begin
            w_addr = r_pc[7:0];
        end else begin
            w_addr = w_alu_result[7:0];
        end
    end

    // RAM read: size bytes from addr upward (wrapping), zero-extended
    always_comb begin
        w_mem_rdata = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (mem_cs && (4'(i) < w_nbytes)) begin
                w_mem_rdata[i*8 +: 8] = r_mem[w_addr + 8'(i)];
            end else begin
                w_mem_rdata[i*8 +: 8] = 8'd0;
            end
        end
    end

    // Data bus: one-hot decode of the source, then an AND-OR merge
    always_comb begin
        w_bus_sel = 4'b0000;
        case (data_tri_sel)
            2'b00:   w_bus_sel = 4'b0001;
            2'b01:   w_bus_sel = 4'b0010;
            2'b10:   w_bus_sel = 4'b0100;
            2'b11:   w_bus_sel = 4'b1000;
            default: w_bus_sel = 4'b0000;
        endcase
        w_data_bus = ({64{w_bus_sel[0]}} & w_alu_result)
                   | ({64{w_bus_sel[1]}} & w_port_b)
                   | ({64{w_bus_sel[2]}} & {32'd0, w_pc_plus4})
                   | ({64{w_bus_sel[3]}} & w_mem_rdata);
    end

    // Register file write; X31 is never written so it stays zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[5'(i)] <= 64'd0;
            end
        end else if (w_reg && (DA != 5'd31)) begin
            r_regs[DA] <= w_data_bus;
        end
    end

    // RAM write of the low size bytes of port B, wrapping past byte 255
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int j = 0; j < 256; j++) begin
                r_mem[8'(j)] <= 8'd0;
            end
        end else if (mem_cs && mem_write_en) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < w_nbytes) begin
                    r_mem[w_addr + 8'(i)] <= w_port_b[i*8 +: 8];
                end
            end
        end
    end

    // Program counter update
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc <= 32'd0;
        end else begin
            case (PC_sel)
                2'b00:   r_pc <= r_pc;
                2'b01:   r_pc <= w_pc_plus4;
                2'b10:   r_pc <= r_pc + {k[29:0], 2'b00};
                2'b11:   r_pc <= w_port_a[31:0];
                default: r_pc <= r_pc;
            endcase
        end
    end

    // Instruction register load from the low half of the data bus
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ir <= 32'd0;
        end else if (IR_load) begin
            r_ir <= w_data_bus[31:0];
        end
    end

    // Status register latches {V,C,N,Z}
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_status <= 4'd0;
        end else if (status_load) begin
            r_status <= {w_flag_v, w_flag_c, w_flag_n, w_flag_z};
        end
    end

    assign IR_out = r_ir;
    assign status = r_status;
    assign r0 = r_regs[0][15:0];
    assign r1 = r_regs[1][15:0];
    assign r2 = r_regs[2][15:0];
    assign r3 = r_regs[3][15:0];
    assign r4 = r_regs[4][15:0];
    assign r5 = r_regs[5][15:0];
    assign r6 = r_regs[6][15:0];
    assign r7 = r_regs[7][15:0];

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: directed steps from the test plan,
// then randomized cycles compared against a behavioural model of the datapath.

module tb_datapath_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        add_tri_sel;
    logic [1:0]  data_tri_sel;
    logic        w_reg;
    logic        C0;
    logic        mem_cs;
    logic        mem_write_en;
    logic        IR_load;
    logic        status_load;
    logic [31:0] k;
    logic [4:0]  FS;
    logic [1:0]  size;
    logic [4:0]  SA, SB, DA;
    logic [1:0]  PC_sel;
    logic        B_Sel;
    logic [31:0] IR_out;
    logic [3:0]  status;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    logic [63:0] m_x   [0:31];
    logic [7:0]  m_mem [0:255];
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_ir = 32'd0;
    logic [3:0]  m_st = 4'd0;

    datapath_core dut (
        .clock(clock), .reset(reset), .add_tri_sel(add_tri_sel),
        .data_tri_sel(data_tri_sel), .w_reg(w_reg), .C0(C0), .mem_cs(mem_cs),
        .mem_write_en(mem_write_en), .IR_load(IR_load), .status_load(status_load),
        .k(k), .FS(FS), .size(size), .SA(SA), .SB(SB), .DA(DA), .PC_sel(PC_sel),
        .B_Sel(B_Sel), .IR_out(IR_out), .status(status),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
    );

    initial begin
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Model of one clock edge: evaluate everything from pre-edge state, then commit
    task automatic model_edge();
        logic [63:0] a, b, bop, aa, bb, res, bus, rd;
        logic [64:0] wide;
        logic signed [64:0] sw;
        logic [7:0] addr;
        logic c, v;
        int nb;
        a   = (SA == 5'd31) ? 64'd0 : m_x[SA];
        b   = (SB == 5'd31) ? 64'd0 : m_x[SB];
        bop = B_Sel ? {32'd0, k} : b;
        aa  = FS[0] ? ~a : a;
        bb  = FS[1] ? ~bop : bop;
        c = 1'b0;
        v = 1'b0;
        case (FS[4:2])
            3'd0: res = aa & bb;
            3'd1: res = aa ^ bb;
            3'd2: begin
                wide = 65'(aa) + 65'(bb) + 65'(C0);
                res  = wide[63:0];
                c    = wide[64];
                sw   = $signed({aa[63], aa}) + $signed({bb[63], bb}) + $signed({64'd0, C0});
                v    = (sw[64] != sw[63]);
            end
            3'd3: res = aa | bb;
            3'd4: res = aa << bb[5:0];
            3'd5: res = aa >> bb[5:0];
            3'd6: res = bb;
            default: res = aa;
        endcase
        addr = add_tri_sel ? m_pc[7:0] : res[7:0];
        nb = 1 << size;
        rd = 64'd0;
        if (mem_cs) begin
            for (int i = 0; i < nb; i++) begin
                rd = rd | (64'(m_mem[(int'(addr) + i) % 256]) << (8 * i));
            end
        end
        case (data_tri_sel)
            2'd0: bus = res;
            2'd1: bus = b;
            2'd2: bus = {32'd0, m_pc + 32'd4};
            default: bus = rd;
        endcase
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
            for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
            m_pc = 32'd0;
            m_ir = 32'd0;
            m_st = 4'd0;
        end else begin
            if (w_reg && DA != 5'd31) m_x[DA] = bus;
            if (mem_cs && mem_write_en) begin
                for (int i = 0; i < nb; i++) m_mem[(int'(addr) + i) % 256] = b[8*i +: 8];
            end
            case (PC_sel)
                2'd1: m_pc = m_pc + 32'd4;
                2'd2: m_pc = m_pc + k * 32'd4;
                2'd3: m_pc = a[31:0];
                default: m_pc = m_pc;
            endcase
            if (IR_load) m_ir = bus[31:0];
            if (status_load) m_st = {v, c, res[63], res == 64'd0};
        end
    endtask

    task automatic check_all();
        check("IR_out", {32'd0, IR_out}, {32'd0, m_ir});
        check("status", {60'd0, status}, {60'd0, m_st});
        check("r0", {48'd0, r0}, {48'd0, m_x[0][15:0]});
        check("r1", {48'd0, r1}, {48'd0, m_x[1][15:0]});
        check("r2", {48'd0, r2}, {48'd0, m_x[2][15:0]});
        check("r3", {48'd0, r3}, {48'd0, m_x[3][15:0]});
        check("r4", {48'd0, r4}, {48'd0, m_x[4][15:0]});
        check("r5", {48'd0, r5}, {48'd0, m_x[5][15:0]});
        check("r6", {48'd0, r6}, {48'd0, m_x[6][15:0]});
        check("r7", {48'd0, r7}, {48'd0, m_x[7][15:0]});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle();
        reset = 1'b1; add_tri_sel = 1'b0; data_tri_sel = 2'b00; w_reg = 1'b0;
        C0 = 1'b0; mem_cs = 1'b0; mem_write_en = 1'b0; IR_load = 1'b0;
        status_load = 1'b0; k = 32'd0; FS = 5'd0; size = 2'b00;
        SA = 5'd0; SB = 5'd0; DA = 5'd0; PC_sel = 2'b00; B_Sel = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
        idle();
        reset = 1'b0;
        tick();
        check("rst_ir", {32'd0, IR_out}, 64'd0);
        check("rst_status", {60'd0, status}, 64'd0);

        // immediate load X0 = 10
        idle(); SA = 5'd31; B_Sel = 1'b1; k = 32'd10; FS = 5'b01100; DA = 5'd0; w_reg = 1'b1;
        tick();
        check("imm_r0", {48'd0, r0}, 64'd10);

        // add X1 = X0 + 5, flags latched
        idle(); SA = 5'd0; B_Sel = 1'b1; k = 32'd5; FS = 5'b01000; DA = 5'd1; w_reg = 1'b1; status_load = 1'b1;
        tick();
        check("add_r1", {48'd0, r1}, 64'd15);
        check("add_status", {60'd0, status}, 64'd0);

        // register move X3 = X0 via port B
        idle(); data_tri_sel = 2'b01; SB = 5'd0; DA = 5'd3; w_reg = 1'b1;
        tick();
        check("mov_r3", {48'd0, r3}, 64'd10);

        // doubleword store X1 at address 0, then load into X4
        idle(); SA = 5'd31; SB = 5'd1; B_Sel = 1'b1; k = 32'd5; size = 2'b11; mem_cs = 1'b1; mem_write_en = 1'b1;
        tick();
        mem_write_en = 1'b0; data_tri_sel = 2'b11; DA = 5'd4; w_reg = 1'b1;
        tick();
        check("ld_r4", {48'd0, r4}, 64'd15);

        // X2 = 0x1FF, byte store at address 16, byte load into X6
        idle(); SA = 5'd31; B_Sel = 1'b1; k = 32'h1FF; FS = 5'b01100; DA = 5'd2; w_reg = 1'b1;
        tick();
        idle(); SA = 5'd31; SB = 5'd2; B_Sel = 1'b1; k = 32'd16; FS = 5'b01100; mem_cs = 1'b1; mem_write_en = 1'b1;
        tick();
        mem_write_en = 1'b0; data_tri_sel = 2'b11; DA = 5'd6; w_reg = 1'b1;
        tick();
        check("ldb_r6", {48'd0, r6}, 64'h0FF);

        // load during doubleword store to the same address returns old bytes
        idle(); SA = 5'd31; SB = 5'd1; B_Sel = 1'b1; k = 32'd16; FS = 5'b01100; size = 2'b11;
        mem_cs = 1'b1; mem_write_en = 1'b1; data_tri_sel = 2'b11; DA = 5'd7; w_reg = 1'b1;
        tick();
        check("rdw_old_r7", {48'd0, r7}, 64'h0FF);
        mem_write_en = 1'b0;
        tick();
        check("rdw_new_r7", {48'd0, r7}, 64'd15);

        // SUB flags: X0 - X0 and 0 - X0
        idle(); SA = 5'd0; SB = 5'd0; FS = 5'b01010; C0 = 1'b1; status_load = 1'b1;
        tick();
        check("sub_zero_status", {60'd0, status}, 64'b0101);
        SA = 5'd31;
        tick();
        check("sub_neg_status", {60'd0, status}, 64'b0010);

        // PC: three increments, observe PC+4 via X5
        idle(); PC_sel = 2'b01;
        tick(); tick(); tick();
        idle(); data_tri_sel = 2'b10; DA = 5'd5; w_reg = 1'b1;
        tick();
        check("pc12_r5", {48'd0, r5}, 64'd16);
        idle(); PC_sel = 2'b10; k = 32'd2;
        tick();
        idle(); data_tri_sel = 2'b10; DA = 5'd5; w_reg = 1'b1;
        tick();
        check("pc20_r5", {48'd0, r5}, 64'd24);

        // IR load
        idle(); SA = 5'd31; B_Sel = 1'b1; k = 32'hDEADBEEF; FS = 5'b01100; IR_load = 1'b1;
        tick();
        check("ir_load", {32'd0, IR_out}, 64'hDEADBEEF);

        // write to X31 is ignored; pass A of X31 into X0
        idle(); SA = 5'd31; B_Sel = 1'b1; k = 32'd123; FS = 5'b01100; DA = 5'd31; w_reg = 1'b1;
        tick();
        idle(); SA = 5'd31; FS = 5'b11100; DA = 5'd0; w_reg = 1'b1;
        tick();
        check("x31_zero_r0", {48'd0, r0}, 64'd0);

        // reset overrides every enable
        idle(); reset = 1'b0; SA = 5'd31; B_Sel = 1'b1; k = 32'h55; FS = 5'b01100; w_reg = 1'b1; DA = 5'd1;
        IR_load = 1'b1; status_load = 1'b1; PC_sel = 2'b01; mem_cs = 1'b1; mem_write_en = 1'b1;
        tick();
        check("rst2_ir", {32'd0, IR_out}, 64'd0);
        check("rst2_status", {60'd0, status}, 64'd0);
        check("rst2_r1", {48'd0, r1}, 64'd0);
        check("rst2_r4", {48'd0, r4}, 64'd0);
        idle(); data_tri_sel = 2'b10; DA = 5'd5; w_reg = 1'b1;
        tick();
        check("rst2_pc_r5", {48'd0, r5}, 64'd4);
        idle(); SA = 5'd31; B_Sel = 1'b1; k = 32'd16; FS = 5'b01100; size = 2'b11; mem_cs = 1'b1;
        data_tri_sel = 2'b11; DA = 5'd6; w_reg = 1'b1;
        tick();
        check("rst2_mem_r6", {48'd0, r6}, 64'd0);

        // randomized cycles against the model
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 39) != 0);
            add_tri_sel  = 1'($urandom);
            data_tri_sel = 2'($urandom);
            w_reg        = 1'($urandom);
            C0           = 1'($urandom);
            mem_cs       = 1'($urandom);
            mem_write_en = 1'($urandom);
            IR_load      = 1'($urandom);
            status_load  = 1'($urandom);
            k            = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            FS           = 5'($urandom);
            size         = 2'($urandom);
            SA           = 5'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 7));
            SB           = 5'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 7));
            DA           = 5'($urandom_range(0, 8) == 0 ? 31 : $urandom_range(0, 7));
            PC_sel       = 2'($urandom);
            B_Sel        = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
